// File: rtl/gb_stream_arbiter.sv
// gb_stream_arbiter
//
// Two-input packet arbiter for Avalon-ST style video streams. The first
// beat of a packet (startofpacket) requests the output. When both inputs
// request at once, the input that was not granted last wins. A granted
// input is connected straight to the output with no added latency, and it
// keeps the output until the end of its packet.
//
// Optional feature (macro GB_ARB_CTRL_LOCK_EN):
//   When defined, the type nibble of each packet is kept in a register.
//   If a control packet (type 4'hF) ends, the same input keeps the grant so
//   that the video packet following it is passed without re-arbitration.
//   When undefined, every packet end returns to IDLE and there is no type
//   register.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   s0_* / s1_*                requester streams (data, valid, ready, sop, eop)
//   dout_*                     arbitrated output stream
//   grant[1:0]                 one-hot owner of dout (bit0 = s0, bit1 = s1),
//                              2'b00 while idle
//
// Parameters:
//   DATA_WIDTH   width of every data bus (must be at least 4)
//   DATA_BITS    bits per colour plane; carried for downstream users, the
//                arbiter itself only looks at data[3:0] of a SOP beat
//
// State table:
//   state | meaning
//   IDLE  | no owner; waiting for a SOP, non-SOP beats are drained
//   GNT0  | s0 owns dout; s0 is passed through combinationally
//   GNT1  | s1 owns dout; s1 is passed through combinationally

module gb_stream_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic                  s0_startofpacket,
  input  logic                  s0_endofpacket,

  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic                  s1_startofpacket,
  input  logic                  s1_endofpacket,

  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,

  output logic [1:0]            grant
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    GNT0 = 3'b010,
    GNT1 = 3'b100
  } state_t;

  state_t state;

  // Input granted most recently; reset to 1 so s0 wins the first tie.
  logic last_id;

  // Low during reset and until the first clock edge afterwards, so the
  // drain path in IDLE cannot show ready while the block is held in reset.
  logic out_en;

  logic req0;
  logic req1;

  // Plane width is informational only; the arbiter never splits the data bus.
  logic [31:0] plane_bits_unused;
  assign plane_bits_unused = DATA_BITS;

  assign req0 = s0_valid & s0_startofpacket;
  assign req1 = s1_valid & s1_startofpacket;

  assign grant = state[2:1];

`ifdef GB_ARB_CTRL_LOCK_EN
  localparam logic [3:0] CTRL_TYPE = 4'hF;

  logic [3:0] pkt_type;
  logic [3:0] cur_type0;
  logic [3:0] cur_type1;

  // On a single-beat packet the type register has not been written yet,
  // so the type of the ending packet comes straight from the SOP beat.
  assign cur_type0 = s0_startofpacket ? s0_data[3:0] : pkt_type;
  assign cur_type1 = s1_startofpacket ? s1_data[3:0] : pkt_type;
`endif

  // Output multiplexer and ready steering.
  always_comb begin
    dout_data          = '0;
    dout_valid         = 1'b0;
    dout_startofpacket = 1'b0;
    dout_endofpacket   = 1'b0;
    s0_ready           = 1'b0;
    s1_ready           = 1'b0;
    case (state)
      GNT0: begin
        dout_data          = s0_data;
        dout_valid         = s0_valid;
        dout_startofpacket = s0_startofpacket;
        dout_endofpacket   = s0_endofpacket;
        s0_ready           = dout_ready;
      end
      GNT1: begin
        dout_data          = s1_data;
        dout_valid         = s1_valid;
        dout_startofpacket = s1_startofpacket;
        dout_endofpacket   = s1_endofpacket;
        s1_ready           = dout_ready;
      end
      default: begin
        // Mid-packet beats arriving while idle belong to an abandoned packet;
        // accept and drop them so the stream resyncs on the next SOP. A SOP
        // beat is held until its input is granted.
        s0_ready = out_en & ~s0_startofpacket;
        s1_ready = out_en & ~s1_startofpacket;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_id <= 1'b1;
      out_en  <= 1'b0;
`ifdef GB_ARB_CTRL_LOCK_EN
      pkt_type <= 4'h0;
`endif
    end else begin
      out_en <= 1'b1;
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            state <= last_id ? GNT0 : GNT1;
          end else if (req0) begin
            state <= GNT0;
          end else if (req1) begin
            state <= GNT1;
          end
        end
        GNT0: begin
          if (s0_valid && dout_ready) begin
`ifdef GB_ARB_CTRL_LOCK_EN
            if (s0_startofpacket) begin
              pkt_type <= s0_data[3:0];
            end
`endif
            if (s0_endofpacket) begin
              last_id <= 1'b0;
`ifdef GB_ARB_CTRL_LOCK_EN
              state <= (cur_type0 == CTRL_TYPE) ? GNT0 : IDLE;
`else
              state <= IDLE;
`endif
            end
          end
        end
        GNT1: begin
          if (s1_valid && dout_ready) begin
`ifdef GB_ARB_CTRL_LOCK_EN
            if (s1_startofpacket) begin
              pkt_type <= s1_data[3:0];
            end
`endif
            if (s1_endofpacket) begin
              last_id <= 1'b1;
`ifdef GB_ARB_CTRL_LOCK_EN
              state <= (cur_type1 == CTRL_TYPE) ? GNT1 : IDLE;
`else
              state <= IDLE;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_stream_arbiter.sv
// Testbench for gb_stream_arbiter: directed packets with a scoreboard queue
// of expected output beats, checked by an independent monitor.
module tb_gb_stream_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s0_data, s1_data, dout_data;
  logic       s0_valid, s0_ready, s0_startofpacket, s0_endofpacket;
  logic       s1_valid, s1_ready, s1_startofpacket, s1_endofpacket;
  logic       dout_valid, dout_ready, dout_startofpacket, dout_endofpacket;
  logic [1:0] grant;

  int errors = 0;
  int checks = 0;
  bit tog_en = 1'b0;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t exp_q[$];

  gb_stream_arbiter #(.DATA_WIDTH(8), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s0_startofpacket(s0_startofpacket), .s0_endofpacket(s0_endofpacket),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .s1_startofpacket(s1_startofpacket), .s1_endofpacket(s1_endofpacket),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat 0 carries the packet type in its low nibble; later beats count up.
  function automatic logic [7:0] beat_data(input logic [7:0] base, input int i, input logic [3:0] typ);
    logic [7:0] v;
    v = base + 8'(i);
    if (i == 0) v[3:0] = typ;
    return v;
  endfunction

  task automatic push_pkt(input logic [1:0] g, input logic [7:0] base, input int len, input logic [3:0] typ);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.g   = g;
      b.d   = beat_data(base, i, typ);
      b.sop = (i == 0);
      b.eop = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic set_src(input bit id, input bit v, input logic [7:0] d, input bit sop, input bit eop);
    if (id) begin
      s1_valid = v; s1_data = d; s1_startofpacket = sop; s1_endofpacket = eop;
    end else begin
      s0_valid = v; s0_data = d; s0_startofpacket = sop; s0_endofpacket = eop;
    end
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic drive_beat(input bit id, input logic [7:0] d, input bit sop, input bit eop);
    int   n;
    logic r;
    set_src(id, 1'b1, d, sop, eop);
    n = 0;
    forever begin
      @(negedge clk);
      r = id ? s1_ready : s0_ready;
      @(posedge clk);
      #1;
      n++;
      if (r) break;
      if (n >= 300) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: s%0d beat %0h never accepted", id, d);
        break;
      end
    end
    set_src(id, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_pkt(input bit id, input logic [7:0] base, input int len, input logic [3:0] typ);
    for (int i = 0; i < len; i++)
      drive_beat(id, beat_data(base, i, typ), i == 0, i == len - 1);
  endtask

  // Single-requester packet from IDLE with explicit one-cycle latency checks.
  task automatic send_pkt_lat(input bit id, input logic [7:0] base, input int len,
                              input logic [3:0] typ, input logic [1:0] g);
    set_src(id, 1'b1, beat_data(base, 0, typ), 1'b1, len == 1);
    @(negedge clk);
    check("grant_idle_before_arb", grant, 2'b00);
    check("dout_valid_idle", dout_valid, 1'b0);
    check("sop_ready_idle", id ? s1_ready : s0_ready, 1'b0);
    @(negedge clk);
    check("grant_after_arb", grant, g);
    @(posedge clk);
    #1;
    set_src(id, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < len; i++)
      drive_beat(id, beat_data(base, i, typ), 1'b0, i == len - 1);
    check("grant_after_eop", grant, 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_src(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_src(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    tog_en = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  initial begin
    beat_t e;
    logic [11:0] got;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (dout_valid && dout_ready) begin
          got = {grant, dout_data, dout_startofpacket, dout_endofpacket};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h with empty queue at %0t", got, $time);
          end else begin
            e = exp_q.pop_front();
            check("dout_beat", got, e);
          end
        end
        if (grant == 2'b01) check("s1_ready_blocked", s1_ready, 1'b0);
        if (grant == 2'b10) check("s0_ready_blocked", s0_ready, 1'b0);
        if (grant == 2'b00) check("idle_dout_valid", dout_valid, 1'b0);
      end
    end
  end

  // dout_ready back-pressure pattern 1,0,1,0 while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) dout_ready = ~dout_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with non-SOP beats present to exercise the drain path.
    rst_n = 1'b0;
    dout_ready = 1'b1;
    set_src(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    set_src(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_s0_ready", s0_ready, 1'b0);
    check("rst_s1_ready", s1_ready, 1'b0);
    do_reset();

    // Single requester, 4-beat packet.
    push_pkt(2'b01, 8'h10, 4, 4'hE);
    send_pkt_lat(1'b0, 8'h10, 4, 4'hE, 2'b01);

    // Round-robin after a fresh reset: s0, s1, s0, s1 with ties each time.
    do_reset();
    push_pkt(2'b01, 8'h20, 2, 4'hE);
    push_pkt(2'b10, 8'h30, 2, 4'hE);
    push_pkt(2'b01, 8'h40, 2, 4'hE);
    push_pkt(2'b10, 8'h50, 2, 4'hE);
    fork
      begin send_pkt(1'b0, 8'h20, 2, 4'hE); send_pkt(1'b0, 8'h40, 2, 4'hE); end
      begin send_pkt(1'b1, 8'h30, 2, 4'hE); send_pkt(1'b1, 8'h50, 2, 4'hE); end
    join
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure 1010 on a 6-beat s0 packet while s1 waits (s1 went last).
    push_pkt(2'b01, 8'h60, 6, 4'hE);
    push_pkt(2'b10, 8'h70, 2, 4'hE);
    tog_en = 1'b1;
    fork
      send_pkt(1'b0, 8'h60, 6, 4'hE);
      send_pkt(1'b1, 8'h70, 2, 4'hE);
    join
    tog_en = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Control packet followed by video from s0 while s1 requests (s1 went last).
    push_pkt(2'b01, 8'hA0, 12, 4'hF);
`ifdef GB_ARB_CTRL_LOCK_EN
    push_pkt(2'b01, 8'hB0, 3, 4'h0);
    push_pkt(2'b10, 8'hC0, 2, 4'hE);
`else
    push_pkt(2'b10, 8'hC0, 2, 4'hE);
    push_pkt(2'b01, 8'hB0, 3, 4'h0);
`endif
    fork
      begin send_pkt(1'b0, 8'hA0, 12, 4'hF); send_pkt(1'b0, 8'hB0, 3, 4'h0); end
      send_pkt(1'b1, 8'hC0, 2, 4'hE);
    join
    repeat (2) @(posedge clk);
    #1;

    // Three stale non-SOP beats on s1 are drained, then a normal packet.
    for (int i = 0; i < 3; i++) begin
      set_src(1'b1, 1'b1, 8'hD1 + 8'(i), 1'b0, 1'b0);
      @(negedge clk);
      check("drain_s1_ready", s1_ready, 1'b1);
      check("drain_dout_valid", dout_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    push_pkt(2'b10, 8'hE0, 3, 4'hE);
    send_pkt_lat(1'b1, 8'hE0, 3, 4'hE, 2'b10);

    // Reset in the middle of an s1 packet.
    push_pkt(2'b10, 8'h80, 2, 4'h5);
    exp_q[exp_q.size() - 1].eop = 1'b0;
    drive_beat(1'b1, beat_data(8'h80, 0, 4'h5), 1'b1, 1'b0);
    drive_beat(1'b1, beat_data(8'h80, 1, 4'h5), 1'b0, 1'b0);
    set_src(1'b1, 1'b1, beat_data(8'h80, 2, 4'h5), 1'b0, 1'b0);
    #1;
    check("pre_rst_grant", grant, 2'b10);
    #1;
    rst_n = 1'b0;
    #1;
    check("midpkt_rst_grant", grant, 2'b00);
    check("midpkt_rst_dout_valid", dout_valid, 1'b0);
    check("midpkt_rst_s1_ready", s1_ready, 1'b0);
    set_src(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_pkt(2'b01, 8'h90, 2, 4'hE);
    send_pkt_lat(1'b0, 8'h90, 2, 4'hE, 2'b01);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
